// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin write-channel arbiter for one crossbar slave port.
// An owner keeps the grant from AW through the last W beat until the B response
// completes, so the AW, W and B muxes always point at the same master.
module axi_wr_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int IDX_WIDTH = 2
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic [NUM_REQ-1:0]   REQ,
   input  logic                 AW_HS,
   input  logic                 W_LAST_HS,
   input  logic                 B_HS,
   output logic [NUM_REQ-1:0]   GRANT,
   output logic [IDX_WIDTH-1:0] GRANT_IDX,
   output logic                 GRANT_VALID,
   output logic                 AW_EN,
   output logic                 W_EN,
   output logic                 B_EN
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
   logic                 grant_valid_q, grant_valid_d;
   logic                 aw_en_q, aw_en_d;
   logic                 w_en_q, w_en_d;
   logic                 b_en_q, b_en_d;
   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
   logic                 w_done_q, w_done_d;
   logic [IDX_WIDTH-1:0] pick;

   // First requester at or after ptr, wrapping to the lowest requester below ptr.
   function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0]   req,
                                                    input logic [IDX_WIDTH-1:0] ptr);
      logic [NUM_REQ-1:0]   sh;
      logic [IDX_WIDTH-1:0] sel;
      sel = '0;
      // Lowest set bit overall: the wrap-around candidate.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sh = req >> i;
         if (sh[0]) sel = IDX_WIDTH'(i);
      end
      // Lowest set bit at or above ptr overrides the wrap candidate.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sh = req >> i;
         if (sh[0] && (i >= int'(ptr))) sel = IDX_WIDTH'(i);
      end
      return sel;
   endfunction

   // Pointer advance past the finishing owner, wrapping at NUM_REQ-1.
   function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] idx);
      if (idx >= IDX_WIDTH'(NUM_REQ - 1)) return '0;
      return idx + IDX_WIDTH'(1);
   endfunction

   assign pick = rr_pick(REQ, ptr_q);

   // Next-state and next-output decode; every output is computed here and registered below.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      aw_en_d       = aw_en_q;
      w_en_d        = w_en_q;
      b_en_d        = b_en_q;
      ptr_d         = ptr_q;
      w_done_d      = w_done_q;
      unique case (state_q)
         IDLE: begin
            // REQ is only looked at here; later changes cannot disturb an owner.
            if (|REQ) begin
               state_d       = ADDR;
               grant_d       = NUM_REQ'(1) << pick;
               grant_idx_d   = pick;
               grant_valid_d = 1'b1;
               aw_en_d       = 1'b1;
               w_en_d        = 1'b1;
               w_done_d      = 1'b0;
            end
         end
         ADDR: begin
            // W may finish before or together with AW; remember an early WLAST.
            if (AW_HS) begin
               aw_en_d = 1'b0;
               if (w_done_q || W_LAST_HS) begin
                  state_d = RESP;
                  w_en_d  = 1'b0;
                  b_en_d  = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end else if (W_LAST_HS) begin
               w_done_d = 1'b1;
            end
         end
         DATA: begin
            if (W_LAST_HS) begin
               state_d = RESP;
               w_en_d  = 1'b0;
               b_en_d  = 1'b1;
            end
         end
         RESP: begin
            // Release; GRANT_IDX keeps the last owner so the pointer math stays valid.
            if (B_HS) begin
               state_d       = IDLE;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               b_en_d        = 1'b0;
               w_done_d      = 1'b0;
               ptr_d         = next_ptr(grant_idx_q);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         aw_en_q       <= 1'b0;
         w_en_q        <= 1'b0;
         b_en_q        <= 1'b0;
         ptr_q         <= '0;
         w_done_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         aw_en_q       <= aw_en_d;
         w_en_q        <= w_en_d;
         b_en_q        <= b_en_d;
         ptr_q         <= ptr_d;
         w_done_q      <= w_done_d;
      end
   end

   assign GRANT       = grant_q;
   assign GRANT_IDX   = grant_idx_q;
   assign GRANT_VALID = grant_valid_q;
   assign AW_EN       = aw_en_q;
   assign W_EN        = w_en_q;
   assign B_EN        = b_en_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed bench for axi_wr_arbiter with hand-computed expectations.
module tb_axi_wr_arbiter;

   localparam int NUM_REQ   = 3;
   localparam int IDX_WIDTH = 2;

   logic                 ACLK;
   logic                 ARESET;
   logic [NUM_REQ-1:0]   REQ;
   logic                 AW_HS;
   logic                 W_LAST_HS;
   logic                 B_HS;
   logic [NUM_REQ-1:0]   GRANT;
   logic [IDX_WIDTH-1:0] GRANT_IDX;
   logic                 GRANT_VALID;
   logic                 AW_EN;
   logic                 W_EN;
   logic                 B_EN;

   int n_cmp;
   int n_mis;

   axi_wr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .REQ         (REQ),
      .AW_HS       (AW_HS),
      .W_LAST_HS   (W_LAST_HS),
      .B_HS        (B_HS),
      .GRANT       (GRANT),
      .GRANT_IDX   (GRANT_IDX),
      .GRANT_VALID (GRANT_VALID),
      .AW_EN       (AW_EN),
      .W_EN        (W_EN),
      .B_EN        (B_EN)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Advance one cycle; sample and drive 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] ix,
                          input logic gv, input logic aw, input logic w, input logic b);
      chk({tag, ".GRANT"},       32'(GRANT),       32'(g));
      chk({tag, ".GRANT_IDX"},   32'(GRANT_IDX),   32'(ix));
      chk({tag, ".GRANT_VALID"}, 32'(GRANT_VALID), 32'(gv));
      chk({tag, ".AW_EN"},       32'(AW_EN),       32'(aw));
      chk({tag, ".W_EN"},        32'(W_EN),        32'(w));
      chk({tag, ".B_EN"},        32'(B_EN),        32'(b));
   endtask

   initial begin
      int order [4];
      logic [2:0] oh;
      n_cmp     = 0;
      n_mis     = 0;
      ARESET    = 1'b1;
      REQ       = '0;
      AW_HS     = 1'b0;
      W_LAST_HS = 1'b0;
      B_HS      = 1'b0;

      // 1: reset, then idle with no requests for 10 cycles
      cyc();
      cyc();
      chk_all("t1_rst", 3'b000, 2'd0, 0, 0, 0, 0);
      ARESET = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk_all("t1_idle", 3'b000, 2'd0, 0, 0, 0, 0);
      end

      // 2: master 1, AW at c2, 4-beat burst ending c6, B at c8
      REQ = 3'b010;                                   // c0
      cyc();                                          // c1
      chk_all("t2_c1", 3'b010, 2'd1, 1, 1, 1, 0);
      REQ = 3'b000;
      cyc();                                          // c2
      chk_all("t2_c2", 3'b010, 2'd1, 1, 1, 1, 0);
      AW_HS = 1'b1;
      cyc();                                          // c3
      AW_HS = 1'b0;
      chk_all("t2_c3", 3'b010, 2'd1, 1, 0, 1, 0);
      cyc();                                          // c4
      cyc();                                          // c5
      cyc();                                          // c6
      chk_all("t2_c6", 3'b010, 2'd1, 1, 0, 1, 0);
      W_LAST_HS = 1'b1;
      cyc();                                          // c7
      W_LAST_HS = 1'b0;
      chk_all("t2_c7", 3'b010, 2'd1, 1, 0, 0, 1);
      cyc();                                          // c8
      chk_all("t2_c8", 3'b010, 2'd1, 1, 0, 0, 1);
      B_HS = 1'b1;
      cyc();                                          // c9
      B_HS = 1'b0;
      chk_all("t2_c9", 3'b000, 2'd1, 0, 0, 0, 0);

      // 3: all requesting, single-beat transactions, pointer from 0 after reset
      ARESET = 1'b1;
      cyc();
      ARESET = 1'b0;
      chk_all("t3_rst", 3'b000, 2'd0, 0, 0, 0, 0);
      order = '{0, 1, 2, 0};
      REQ = 3'b111;
      for (int i = 0; i < 4; i++) begin
         oh = 3'b001 << order[i];
         cyc();
         chk_all("t3_grant", oh, 2'(order[i]), 1, 1, 1, 0);
         AW_HS     = 1'b1;
         W_LAST_HS = 1'b1;
         cyc();
         AW_HS     = 1'b0;
         W_LAST_HS = 1'b0;
         chk_all("t3_resp", oh, 2'(order[i]), 1, 0, 0, 1);
         B_HS = 1'b1;
         cyc();
         B_HS = 1'b0;
         chk_all("t3_gap", 3'b000, 2'(order[i]), 0, 0, 0, 0);
         if (i == 3) REQ = 3'b000;
      end
      cyc();
      chk_all("t3_end", 3'b000, 2'd0, 0, 0, 0, 0);

      // 4: W before AW for master 2 (pointer is 1)
      REQ = 3'b100;                                   // c0
      cyc();                                          // c1
      chk_all("t4_c1", 3'b100, 2'd2, 1, 1, 1, 0);
      REQ = 3'b000;
      cyc();                                          // c2
      W_LAST_HS = 1'b1;
      cyc();                                          // c3
      W_LAST_HS = 1'b0;
      chk_all("t4_c3", 3'b100, 2'd2, 1, 1, 1, 0);
      cyc();                                          // c4
      chk_all("t4_c4", 3'b100, 2'd2, 1, 1, 1, 0);
      AW_HS = 1'b1;
      cyc();                                          // c5
      AW_HS = 1'b0;
      chk_all("t4_c5", 3'b100, 2'd2, 1, 0, 0, 1);
      W_LAST_HS = 1'b1;
      cyc();                                          // c6
      W_LAST_HS = 1'b0;
      chk_all("t4_c6", 3'b100, 2'd2, 1, 0, 0, 1);
      B_HS = 1'b1;
      cyc();
      B_HS = 1'b0;
      chk_all("t4_done", 3'b000, 2'd2, 0, 0, 0, 0);

      // 5: reset during DATA, then REQ=011 goes to master 0
      REQ = 3'b010;                                   // c0 (pointer 0)
      cyc();                                          // c1
      chk_all("t5_c1", 3'b010, 2'd1, 1, 1, 1, 0);
      REQ   = 3'b000;
      AW_HS = 1'b1;
      cyc();                                          // c2
      AW_HS = 1'b0;
      chk_all("t5_data", 3'b010, 2'd1, 1, 0, 1, 0);
      ARESET = 1'b1;
      cyc();                                          // c3
      ARESET = 1'b0;
      chk_all("t5_rst", 3'b000, 2'd0, 0, 0, 0, 0);
      REQ = 3'b011;
      cyc();                                          // c4
      chk_all("t5_regrant", 3'b001, 2'd0, 1, 1, 1, 0);
      REQ       = 3'b000;
      AW_HS     = 1'b1;
      W_LAST_HS = 1'b1;
      cyc();
      AW_HS     = 1'b0;
      W_LAST_HS = 1'b0;
      chk_all("t5_resp", 3'b001, 2'd0, 1, 0, 0, 1);
      B_HS = 1'b1;
      cyc();
      B_HS = 1'b0;
      chk_all("t5_done", 3'b000, 2'd0, 0, 0, 0, 0);

      // 6: spurious handshakes and REQ changes while owned (pointer is 1, master 2 idle)
      REQ = 3'b001;                                   // c0: wrap to master 0
      cyc();                                          // c1 ADDR
      chk_all("t6_c1", 3'b001, 2'd0, 1, 1, 1, 0);
      REQ  = 3'b110;
      B_HS = 1'b1;
      cyc();                                          // c2 still ADDR
      B_HS = 1'b0;
      chk_all("t6_addr", 3'b001, 2'd0, 1, 1, 1, 0);
      AW_HS = 1'b1;
      cyc();                                          // c3 DATA
      AW_HS = 1'b0;
      chk_all("t6_data", 3'b001, 2'd0, 1, 0, 1, 0);
      AW_HS = 1'b1;
      B_HS  = 1'b1;
      cyc();                                          // c4 still DATA
      AW_HS = 1'b0;
      B_HS  = 1'b0;
      chk_all("t6_data2", 3'b001, 2'd0, 1, 0, 1, 0);
      REQ       = 3'b000;
      W_LAST_HS = 1'b1;
      cyc();                                          // c5 RESP
      W_LAST_HS = 1'b0;
      chk_all("t6_resp", 3'b001, 2'd0, 1, 0, 0, 1);
      B_HS = 1'b1;
      cyc();
      B_HS = 1'b0;
      chk_all("t6_done", 3'b000, 2'd0, 0, 0, 0, 0);
      cyc();
      chk_all("t6_idle", 3'b000, 2'd0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Per-slave-port write-channel arbiter for axi_crossbar.
- One instance per M_AXI port. Shares that downstream slave between AXI_SLAVE_PORT upstream masters using round-robin.
- Locks the grant across the AW handshake, the full W burst and the B response, so AW, W and B routing always agree.
- Its grant and enable outputs drive the crossbar's AW/W/B muxes and demuxes for that slave.

Parameters:
- NUM_REQ, 3, number of requesting masters (crossbar AXI_SLAVE_PORT).
- IDX_WIDTH, 2, width of the grant index; must satisfy 2**IDX_WIDTH >= NUM_REQ.

Ports:
- ACLK  input  1  clock; all logic on rising edge.
- ARESET  input  1  synchronous, active-high reset.
- REQ  input  NUM_REQ  bit i = master i AWVALID, address-decoded to this slave.
- AW_HS  input  1  slave-side AWVALID & AWREADY.
- W_LAST_HS  input  1  slave-side WVALID & WREADY & WLAST.
- B_HS  input  1  slave-side BVALID & BREADY.
- GRANT  output  NUM_REQ  one-hot owning master; all zero when idle.
- GRANT_IDX  output  IDX_WIDTH  binary index of the owner; holds its last value when idle.
- GRANT_VALID  output  1  an owner exists (state != IDLE).
- AW_EN  output  1  route the owner's AW channel to the slave.
- W_EN  output  1  route the owner's W channel to the slave.
- B_EN  output  1  route the slave's B channel to the owner.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; GRANT=0; GRANT_IDX=0; GRANT_VALID=0; AW_EN=0; W_EN=0; B_EN=0; round-robin pointer=0; w_done=0.
- ARESET high mid-transaction forces the reset values on the next edge. In-flight ownership is abandoned; no completion is required.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If REQ != 0, choose the first set bit at or after the pointer, scanning upward with wrap modulo NUM_REQ.
  - Next edge: load GRANT/GRANT_IDX, set GRANT_VALID=1, AW_EN=1, W_EN=1, go to ADDR.
  - REQ-to-GRANT latency is 1 cycle.
- ADDR (AW_EN=1, W_EN=1; W may be accepted before or with AW):
  - AW_HS & (w_done | W_LAST_HS) -> RESP.
  - AW_HS only -> DATA.
  - W_LAST_HS without AW_HS -> set w_done, stay in ADDR.
- DATA (AW_EN=0, W_EN=1):
  - W_LAST_HS -> RESP.
- RESP (AW_EN=0, W_EN=0, B_EN=1):
  - B_HS -> IDLE. Clear GRANT, GRANT_VALID and B_EN; clear w_done; pointer = (GRANT_IDX+1) mod NUM_REQ.
- Idle gap: after B_HS, at least 1 cycle in IDLE before the next grant. B_HS-to-next-GRANT is 2 edges.
- Ignored inputs:
  - AW_HS outside ADDR.
  - W_LAST_HS in RESP/IDLE, or a second W_LAST_HS in ADDR after w_done.
  - B_HS outside RESP.
- REQ is sampled only in IDLE. Deassertion of the owner's REQ after grant has no effect.
- The pointer is modified only on B_HS in RESP.
- The pointer wraps from NUM_REQ-1 to 0. REQ bits at index >= NUM_REQ cannot exist; GRANT_IDX never exceeds NUM_REQ-1.
- One outstanding write per slave port: no overlap of two owners.

Test Plan:
1. Reset, REQ=3'b000 for 10 cycles -> all outputs 0, state IDLE throughout.
2. REQ=3'b010 at cycle 0; AW_HS at cycle 2; 4-beat burst with W_LAST_HS at cycle 6; B_HS at cycle 8.
   - Required: GRANT=3'b010 and GRANT_IDX=1 from cycle 1; AW_EN 1 for cycles 1-2; W_EN 1 for cycles 1-6; B_EN 1 for cycles 7-8; GRANT=0 at cycle 9.
3. REQ=3'b111 held, each transaction single-beat with AW_HS and W_LAST_HS in the same cycle.
   - Required: grants in order 0,1,2,0. Each grant is 2 cycles after the previous B_HS.
4. W before AW: after grant to master 2, W_LAST_HS at cycle 2, AW_HS at cycle 4.
   - Required: w_done=1 and state stays ADDR through cycle 4; RESP from cycle 5. A spurious W_LAST_HS at cycle 5 is ignored.
5. Mid-burst reset: grant master 1, AW_HS done, ARESET=1 during DATA.
   - Required: next edge all outputs 0 and pointer=0.
   - With REQ=3'b011 after release: grant goes to master 0.
6. Spurious handshakes: B_HS while in ADDR or DATA and AW_HS while in DATA -> no state change, no grant change.
